// File: rtl/float_divide_if.sv
// Handshake and result bundle for the sequential binary32 divider.
interface float_divide_if;
  logic        start;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic        exception;
  logic        divide_by_zero;
  logic        overflow;
  logic        underflow;
  logic        zero;

  modport master (
    output start, A, B,
    input  busy, done, quotient, exception, divide_by_zero, overflow, underflow, zero
  );

  modport slave (
    input  start, A, B,
    output busy, done, quotient, exception, divide_by_zero, overflow, underflow, zero
  );
endinterface

// File: rtl/float_divide.sv
// Sequential binary32 divider: radix-2 restoring mantissa division, one
// quotient bit per cycle, fixed 28-cycle latency from accept to done.
module float_divide (
  input  logic           clk,
  input  logic           rst,
  float_divide_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, DIV, ROUND} state_t;

  state_t      state_q;
  logic        sign_q;
  logic [7:0]  ea_q, eb_q;
  logic [23:0] mb_q;
  logic [24:0] rem_q;
  logic [26:0] q_q;
  logic [4:0]  cnt_q;
  logic        exc_q, dbz_q, zro_q;
  logic        busy_q, done_q;
  logic [31:0] quot_q;
  logic        exc_o_q, dbz_o_q, ovf_o_q, unf_o_q, zro_o_q;

  // One restoring step: subtract divisor when it fits, then shift left.
  logic        ge_d;
  logic [24:0] diff_d, rem_d;
  always_comb begin
    ge_d   = rem_q >= {1'b0, mb_q};
    diff_d = rem_q - {1'b0, mb_q};
    rem_d  = ge_d ? {diff_d[23:0], 1'b0} : {rem_q[23:0], 1'b0};
  end

  // Normalize the 27-bit quotient, round to nearest even, form exponent.
  logic        hi_d, g_d, s_d, rup_d;
  logic [22:0] mant_d;
  logic [23:0] msum_d;
  logic signed [9:0] exp_d;
  logic        ovf_d, unf_d;
  always_comb begin
    hi_d   = q_q[26];
    mant_d = hi_d ? q_q[25:3] : q_q[24:2];
    g_d    = hi_d ? q_q[2] : q_q[1];
    s_d    = (hi_d ? |q_q[1:0] : q_q[0]) | (rem_q != 25'd0);
    rup_d  = g_d & (s_d | mant_d[0]);
    msum_d = {1'b0, mant_d} + {23'd0, rup_d};
    exp_d  = {2'b00, ea_q} - {2'b00, eb_q} + 10'd127 - {9'd0, ~hi_d} + {9'd0, msum_d[23]};
    ovf_d  = exp_d >= 10'sd255;
    unf_d  = exp_d <= 10'sd0;
  end

  // Control FSM, datapath registers and registered result/flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sign_q  <= 1'b0;
      ea_q    <= '0;
      eb_q    <= '0;
      mb_q    <= '0;
      rem_q   <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
      exc_q   <= 1'b0;
      dbz_q   <= 1'b0;
      zro_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quot_q  <= '0;
      exc_o_q <= 1'b0;
      dbz_o_q <= 1'b0;
      ovf_o_q <= 1'b0;
      unf_o_q <= 1'b0;
      zro_o_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (bus.start) begin
          state_q <= DIV;
          busy_q  <= 1'b1;
          sign_q  <= bus.A[31] ^ bus.B[31];
          ea_q    <= bus.A[30:23];
          eb_q    <= bus.B[30:23];
          mb_q    <= {1'b1, bus.B[22:0]};
          rem_q   <= {2'b01, bus.A[22:0]};
          q_q     <= '0;
          cnt_q   <= '0;
          // Exponent 0 is treated as zero (denormals flushed); priority is
          // resolved at pack time, so the classes may overlap here.
          exc_q   <= (&bus.A[30:23]) | (&bus.B[30:23]) |
                     ((bus.A[30:23] == 8'd0) & (bus.B[30:23] == 8'd0));
          dbz_q   <= bus.B[30:23] == 8'd0;
          zro_q   <= bus.A[30:23] == 8'd0;
        end
        DIV: begin
          q_q   <= {q_q[25:0], ge_d};
          rem_q <= rem_d;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd26) state_q <= ROUND;
        end
        ROUND: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          exc_o_q <= 1'b0;
          dbz_o_q <= 1'b0;
          ovf_o_q <= 1'b0;
          unf_o_q <= 1'b0;
          zro_o_q <= 1'b0;
          if (exc_q) begin
            quot_q <= 32'd0;            exc_o_q <= 1'b1;
          end else if (dbz_q) begin
            quot_q <= {sign_q, 8'hFF, 23'd0}; dbz_o_q <= 1'b1;
          end else if (zro_q) begin
            quot_q <= {sign_q, 31'd0};  zro_o_q <= 1'b1;
          end else if (ovf_d) begin
            quot_q <= {sign_q, 8'hFF, 23'd0}; ovf_o_q <= 1'b1;
          end else if (unf_d) begin
            quot_q <= {sign_q, 31'd0};  unf_o_q <= 1'b1;
          end else begin
            quot_q <= {sign_q, exp_d[7:0], msum_d[22:0]};
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.quotient       = quot_q;
  assign bus.exception      = exc_o_q;
  assign bus.divide_by_zero = dbz_o_q;
  assign bus.overflow       = ovf_o_q;
  assign bus.underflow      = unf_o_q;
  assign bus.zero           = zro_o_q;

endmodule

// File: tb/tb_float_divide.sv
// Self-checking bench for float_divide: directed spec vectors, random
// operands against an exact-division reference, handshake and reset timing.
module tb_float_divide;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  float_divide_if bus();
  float_divide dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // Result word: {quotient, exception, divide_by_zero, overflow, underflow, zero}
  function automatic logic [36:0] dut_res();
    return {bus.quotient, bus.exception, bus.divide_by_zero, bus.overflow,
            bus.underflow, bus.zero};
  endfunction

  // Reference: exact integer division of the significands, rounded to
  // nearest-even by comparing twice the remainder with the divisor.
  function automatic logic [36:0] model(input logic [31:0] a, input logic [31:0] b);
    int ea, eb, e;
    longint ma, mb, qi, r, one24;
    logic s;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    if (ea == 255 || eb == 255 || (ea == 0 && eb == 0)) return {32'd0, 5'b10000};
    if (eb == 0) return {s, 8'hFF, 23'd0, 5'b01000};
    if (ea == 0) return {s, 31'd0, 5'b00001};
    ma = longint'({1'b1, a[22:0]});
    mb = longint'({1'b1, b[22:0]});
    e  = ea - eb + 127;
    if (ma >= mb) begin
      qi = (ma << 23) / mb; r = (ma << 23) % mb;
    end else begin
      qi = (ma << 24) / mb; r = (ma << 24) % mb; e = e - 1;
    end
    if (2 * r > mb || (2 * r == mb && (qi % 2) == 1)) qi = qi + 1;
    one24 = longint'(1) << 24;
    if (qi == one24) begin qi = one24 >> 1; e = e + 1; end
    if (e >= 255) return {s, 8'hFF, 23'd0, 5'b00100};
    if (e <= 0) return {s, 31'd0, 5'b00010};
    return {s, 8'(e), 23'(qi), 5'b00000};
  endfunction

  // Launch one operation and wait (bounded) for done.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                       output logic [36:0] res, output int lat, output int bcnt);
    @(negedge clk);
    bus.start = 1'b1; bus.A = a; bus.B = b;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.A = $urandom; bus.B = $urandom;
    lat = 0; bcnt = 0;
    while (lat < 60) begin
      if (bus.busy) bcnt++;
      @(posedge clk); #1;
      lat++;
      if (bus.done) break;
    end
    if (!bus.done) lat = -1;
    res = dut_res();
  endtask

  task automatic test_reset();
    #2;
    tests++;
    if ({dut_res(), bus.busy, bus.done} !== 39'd0) begin
      fails++; $display("FAIL reset_state got=%h exp=0", {dut_res(), bus.busy, bus.done});
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [36:0] res; int lat, bcnt;
    do_op(32'h40C00000, 32'h40000000, res, lat, bcnt);
    tests++;
    if (res !== {32'h40400000, 5'b0}) begin
      fails++; $display("FAIL basic_6div2 got=%h exp=%h", res, {32'h40400000, 5'b0});
    end
    tests++;
    if (lat !== 28) begin fails++; $display("FAIL basic_latency got=%0d exp=28", lat); end
    tests++;
    if (bcnt !== 28) begin fails++; $display("FAIL basic_busy_cycles got=%0d exp=28", bcnt); end
    tests++;
    if (bus.busy !== 1'b0) begin fails++; $display("FAIL busy_at_done got=%b exp=0", bus.busy); end
    @(posedge clk); #1;
    tests++;
    if (bus.done !== 1'b0 || dut_res() !== res) begin
      fails++; $display("FAIL done_pulse_hold done=%b res=%h exp_res=%h", bus.done, dut_res(), res);
    end
  endtask

  task automatic test_directed();
    logic [31:0] va [9] = '{32'h3F800000, 32'hC0F00000, 32'h3F800000, 32'h00000000,
                            32'h7F800000, 32'h7F000000, 32'h00800000, 32'h00000000, 32'h40C00000};
    logic [31:0] vb [9] = '{32'h40400000, 32'h40200000, 32'h00000000, 32'h00000000,
                            32'h3F800000, 32'h00800000, 32'h40000000, 32'h3F800000, 32'h40000000};
    logic [36:0] ve [9] = '{{32'h3EAAAAAB, 5'b00000}, {32'hC0400000, 5'b00000},
                            {32'h7F800000, 5'b01000}, {32'h00000000, 5'b10000},
                            {32'h00000000, 5'b10000}, {32'h7F800000, 5'b00100},
                            {32'h00000000, 5'b00010}, {32'h00000000, 5'b00001},
                            {32'h40400000, 5'b00000}};
    logic [36:0] res; int lat, bcnt;
    for (int i = 0; i < 9; i++) begin
      do_op(va[i], vb[i], res, lat, bcnt);
      tests++;
      if (res !== ve[i] || lat !== 28) begin
        fails++;
        $display("FAIL directed_%0d %h/%h got=%h lat=%0d exp=%h lat=28", i, va[i], vb[i], res, lat, ve[i]);
      end
      tests++;
      if (model(va[i], vb[i]) !== ve[i]) begin
        fails++; $display("FAIL model_directed_%0d got=%h exp=%h", i, model(va[i], vb[i]), ve[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b; logic [36:0] res, exp_r; int lat, bcnt;
    for (int i = 0; i < 40; i++) begin
      if (($urandom % 4) != 0) begin
        a = {1'($urandom), 8'($urandom_range(1, 254)), 23'($urandom)};
        b = {1'($urandom), 8'($urandom_range(1, 254)), 23'($urandom)};
      end else begin
        a = $urandom; b = $urandom;
        if ($urandom % 2) a[30:23] = 8'(($urandom % 2) ? 0 : 255);
      end
      exp_r = model(a, b);
      do_op(a, b, res, lat, bcnt);
      tests++;
      if (res !== exp_r || lat !== 28) begin
        fails++; $display("FAIL random_%0d %h/%h got=%h lat=%0d exp=%h", i, a, b, res, lat, exp_r);
      end
    end
  endtask

  task automatic test_ignore_start();
    int n;
    @(negedge clk);
    bus.start = 1'b1; bus.A = 32'h3F800000; bus.B = 32'h40400000;
    @(posedge clk); #1;
    bus.start = 1'b0;
    n = 0;
    while (n < 60) begin
      @(posedge clk); #1;
      n++;
      bus.start = 1'b0;
      if (bus.done) break;
      if (n == 5 || n == 20) begin
        bus.start = 1'b1; bus.A = 32'h40C00000; bus.B = 32'h40000000;
      end
    end
    tests++;
    if (n !== 28 || dut_res() !== {32'h3EAAAAAB, 5'b0}) begin
      fails++; $display("FAIL ignore_start got=%h at=%0d exp=%h at=28", dut_res(), n, {32'h3EAAAAAB, 5'b0});
    end
    repeat (35) @(posedge clk);
    #1;
    tests++;
    if (bus.busy !== 1'b0 || dut_res() !== {32'h3EAAAAAB, 5'b0}) begin
      fails++; $display("FAIL ignore_no_queue busy=%b res=%h exp busy=0", bus.busy, dut_res());
    end
  endtask

  task automatic test_back_to_back();
    logic [36:0] res; int lat, bcnt, n;
    do_op(32'h40C00000, 32'h40000000, res, lat, bcnt);
    bus.start = 1'b1; bus.A = 32'hC0F00000; bus.B = 32'h40200000;
    n = 0;
    while (n < 80) begin
      @(posedge clk); #1;
      n++;
      if (n == 1) begin
        bus.start = 1'b0;
        tests++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b1) begin
          fails++; $display("FAIL b2b_accept done=%b busy=%b exp done=0 busy=1", bus.done, bus.busy);
        end
      end
      if (bus.done) break;
    end
    tests++;
    if (n !== 29 || dut_res() !== {32'hC0400000, 5'b0}) begin
      fails++; $display("FAIL back_to_back got=%h gap=%0d exp=%h gap=29", dut_res(), n, {32'hC0400000, 5'b0});
    end
  endtask

  task automatic test_reset_mid();
    logic [36:0] res; int lat, bcnt, dn;
    do_op(32'h40C00000, 32'h40000000, res, lat, bcnt);
    @(negedge clk);
    bus.start = 1'b1; bus.A = 32'h3F800000; bus.B = 32'h40400000;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    tests++;
    if ({dut_res(), bus.busy, bus.done} !== 39'd0) begin
      fails++; $display("FAIL reset_mid got=%h exp=0", {dut_res(), bus.busy, bus.done});
    end
    @(negedge clk); rst = 1'b0;
    dn = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.done) dn++;
    end
    tests++;
    if (dn !== 0) begin fails++; $display("FAIL reset_no_done got=%0d exp=0", dn); end
    do_op(32'h3F800000, 32'h40400000, res, lat, bcnt);
    tests++;
    if (res !== {32'h3EAAAAAB, 5'b0} || lat !== 28) begin
      fails++; $display("FAIL after_reset got=%h lat=%0d exp=%h lat=28", res, lat, {32'h3EAAAAAB, 5'b0});
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.A = '0; bus.B = '0;
    test_reset();
    test_basic();
    test_directed();
    test_random();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
